result_evaluator: RTL
=====================

# result_evaluator

- Reads the operands and operator captured by the keypad memory stage: two 3-digit BCD numbers and an operator code.
- Computes the arithmetic result sequentially: BCD→binary, execute, binary→BCD via iterative double-dabble.
- Presents a 6-digit BCD result with sign and error flags to the display stage, with a start/busy/done handshake.
- Sits between the entry memory and the 7-segment display driver on the 1 ms clock domain.

## Interface
Parameters:
- none

Ports:
- Clock_1ms  input  1  system clock; all state changes on rising edge
- Reset_n  input  1  asynchronous, active-low reset
- start  input  1  request evaluation; sampled only in IDLE
- operandMemory  input  4  operator: 4'hA add, 4'hB subtract, 4'hC multiply, 4'hD divide
- number1Memory  input  12  first operand, 3 packed BCD digits, [11:8] most significant
- number2Memory  input  12  second operand, same format
- busy  output  1  evaluation in progress
- done  output  1  one-cycle pulse: result outputs valid and updated
- resultBCD  output  24  6 packed BCD digits, [23:20] most significant
- negative  output  1  result is negative (subtract only)
- error  output  1  last evaluation rejected

## Operation
States:
- IDLE: start=1 → capture inputs, convert to binary (d2*100+d1*10+d0, 10 bits each), busy←1.
  - Any BCD digit >9, operator not A–D, or divide with operand2=0 → ERR.
  - Else → EXEC.
- EXEC:
  - Add, subtract, multiply: one cycle.
  - Subtract: if n1≥n2 the result is n1−n2 with negative=0; else n2−n1 with negative=1.
  - Divide: restoring division, 10 cycles, one quotient bit per cycle; quotient truncated.
  - Result held as 20-bit binary; maximum 998001 < 2^20.
  - → CONV.
- CONV: double-dabble, exactly 20 cycles regardless of value (add-3 on digits ≥5, then shift). → DONE.
- DONE: resultBCD and negative update, error←0, done=1, busy←0. → IDLE.
- ERR: resultBCD←0, negative←0, error←1, done=1, busy←0. → IDLE.

Rules:
- Inputs are captured once in IDLE; later input changes do not affect an evaluation in flight.
- start is ignored while busy=1. start held high re-triggers on the first IDLE cycle after done.
- resultBCD, negative and error hold their values until the next DONE or ERR.
- Reset (asynchronous, any state): IDLE, busy=0, done=0, resultBCD=24'h000000, negative=0, error=0, internal registers cleared. Any evaluation in flight is abandoned with no done pulse.

## Timing
Edge numbering: edge 0 is the rising edge at which IDLE samples start=1.

- Add, subtract, multiply: EXEC at edge 1, CONV edges 2–21. done=1 and the new result are visible after edge 22, for one cycle.
- Divide: EXEC edges 1–10, CONV edges 11–30. done is visible after edge 31.
- Error: done and error are visible after edge 1.
- busy rises after edge 0 and falls on the same edge that raises done.
- Earliest next start sample: the edge after done (edge 23 for add).

## Configuration
- EVAL_REMAINDER_EN defined:
  - Divide reports the quotient BCD in resultBCD[11:0] and the remainder BCD in resultBCD[23:12].
  - A second 10-bit double-dabble converter runs in parallel during the same 20 CONV cycles.
  - Latency is unchanged.
- EVAL_REMAINDER_EN undefined:
  - Divide reports the quotient only; resultBCD[23:12]=0.
  - The remainder converter is not built.
- Add, subtract and multiply are identical in both builds.

## Test plan
- 123 + 456 (A, 12'h123, 12'h456), start at edge 0 → resultBCD=24'h000579, negative=0, error=0, one-cycle done after edge 22, busy high edges 0–22.
- 005 − 010 (B) → resultBCD=24'h000005, negative=1; a following 010 − 005 → 24'h000005, negative=0.
- 999 × 999 (C) → resultBCD=24'h998001 after edge 22. Changing number1Memory during busy does not alter the result.
- 100 ÷ 007 (D) → done after edge 31.
  - Without EVAL_REMAINDER_EN: resultBCD=24'h000014.
  - With EVAL_REMAINDER_EN: resultBCD=24'h002014.
- Error cases → each gives a done pulse after edge 1 with error=1, resultBCD=0; the next valid evaluation clears error:
  - 123 ÷ 000.
  - Operator 4'h5.
  - number1Memory=12'h1A3.
- Reset_n low at edge 10 of a multiply → outputs zero immediately with no done. start ignored at edge 5 of a run; only one done pulse results.

Source files
------------

// File: rtl/result_evaluator.sv
// Sequential BCD calculator: captures two 3-digit BCD operands, computes add/sub/mul/div
// in binary, and converts back to 6-digit BCD by double-dabble. Option: EVAL_REMAINDER_EN.
module result_evaluator (
   input  logic        Clock_1ms,
   input  logic        Reset_n,
   input  logic        start,
   input  logic [3:0]  operandMemory,
   input  logic [11:0] number1Memory,
   input  logic [11:0] number2Memory,
   output logic        busy,
   output logic        done,
   output logic [23:0] resultBCD,
   output logic        negative,
   output logic        error
);

   // state | meaning
   // IDLE  | waiting for start; inputs captured and validated on start
   // EXEC  | arithmetic; one cycle, or ten for restoring division
   // CONV  | twenty double-dabble steps
   // DONE  | commit result, pulse done
   // ERR   | commit error, pulse done
   typedef enum logic [2:0] {S_IDLE, S_EXEC, S_CONV, S_DONE, S_ERR} state_t;

   localparam logic [3:0] OP_ADD = 4'hA;
   localparam logic [3:0] OP_SUB = 4'hB;
   localparam logic [3:0] OP_MUL = 4'hC;
   localparam logic [3:0] OP_DIV = 4'hD;

   function automatic logic [9:0] bcd_to_bin(input logic [11:0] d);
      return {6'b0, d[11:8]} * 10'd100 + {6'b0, d[7:4]} * 10'd10 + {6'b0, d[3:0]};
   endfunction

   function automatic logic bcd_ok(input logic [11:0] d);
      return (d[11:8] <= 4'd9) && (d[7:4] <= 4'd9) && (d[3:0] <= 4'd9);
   endfunction

   function automatic logic [3:0] add3(input logic [3:0] v);
      return (v >= 4'd5) ? v + 4'd3 : v;
   endfunction

   state_t      state, state_nx;
   logic [3:0]  op_r;
   logic [9:0]  a_bin, b_bin;
   logic [9:0]  quo, rem_p;
   logic [4:0]  cnt;
   logic [19:0] bin_sh;
   logic [23:0] bcd_sh;
   logic        neg_r;

   logic        in_bad, exec_last, load_en, commit, fail;
   logic [10:0] div_sh;
   logic        div_fit;
   logic [9:0]  quo_nx, rem_nx;
   logic [19:0] exec_val;
   logic        exec_neg;
   logic [19:0] bcd_adj;

   assign in_bad = !bcd_ok(number1Memory) || !bcd_ok(number2Memory) ||
                   (operandMemory < OP_ADD) || (operandMemory > OP_DIV) ||
                   ((operandMemory == OP_DIV) && (number2Memory == 12'h000));

   // one restoring-division step: shift in the next dividend bit, subtract if it fits
   assign div_sh  = {rem_p, quo[9]};
   assign div_fit = (div_sh >= {1'b0, b_bin});
   assign rem_nx  = div_fit ? 10'(div_sh - {1'b0, b_bin}) : div_sh[9:0];
   assign quo_nx  = {quo[8:0], div_fit};

   always_comb begin
      exec_val = '0;
      exec_neg = 1'b0;
      case (op_r)
         OP_ADD: exec_val = {10'b0, a_bin} + {10'b0, b_bin};
         OP_SUB: begin
            if (a_bin >= b_bin) begin
               exec_val = {10'b0, a_bin - b_bin};
            end else begin
               exec_val = {10'b0, b_bin - a_bin};
               exec_neg = 1'b1;
            end
         end
         OP_MUL: exec_val = {10'b0, a_bin} * {10'b0, b_bin};
         OP_DIV: exec_val = {10'b0, quo_nx};
         default: exec_val = '0;
      endcase
   end

   assign exec_last = (op_r != OP_DIV) || (cnt == 5'd0);

   // the top digit never reaches 5 before the final shift, so only the low five need adjusting
   always_comb begin
      bcd_adj = '0;
      for (int i = 0; i < 5; i++) begin
         bcd_adj[4*i +: 4] = add3(bcd_sh[4*i +: 4]);
      end
   end

`ifdef EVAL_REMAINDER_EN
   logic [19:0] rbin_sh;
   logic [11:0] rbcd_sh;
   logic [7:0]  rbcd_adj;

   assign rbcd_adj = {add3(rbcd_sh[7:4]), add3(rbcd_sh[3:0])};
`endif

   always_ff @(posedge Clock_1ms or negedge Reset_n) begin
      if (!Reset_n) state <= S_IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (start) state_nx = in_bad ? S_ERR : S_EXEC;
         S_EXEC: if (exec_last) state_nx = S_CONV;
         S_CONV: if (cnt == 5'd0) state_nx = S_DONE;
         S_DONE: state_nx = S_IDLE;
         S_ERR:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      busy    = (state != S_IDLE);
      load_en = (state == S_IDLE) && start;
      commit  = (state == S_DONE);
      fail    = (state == S_ERR);
   end

   always_ff @(posedge Clock_1ms or negedge Reset_n) begin
      if (!Reset_n) begin
         op_r      <= '0;
         a_bin     <= '0;
         b_bin     <= '0;
         quo       <= '0;
         rem_p     <= '0;
         cnt       <= '0;
         bin_sh    <= '0;
         bcd_sh    <= '0;
         neg_r     <= 1'b0;
         done      <= 1'b0;
         resultBCD <= '0;
         negative  <= 1'b0;
         error     <= 1'b0;
`ifdef EVAL_REMAINDER_EN
         rbin_sh   <= '0;
         rbcd_sh   <= '0;
`endif
      end else begin
         done <= 1'b0;
         if (load_en) begin
            op_r  <= operandMemory;
            a_bin <= bcd_to_bin(number1Memory);
            b_bin <= bcd_to_bin(number2Memory);
            quo   <= bcd_to_bin(number1Memory);
            rem_p <= '0;
            cnt   <= 5'd9;
         end
         if (state == S_EXEC) begin
            quo   <= quo_nx;
            rem_p <= rem_nx;
            cnt   <= exec_last ? 5'd19 : cnt - 5'd1;
            if (exec_last) begin
               bin_sh <= exec_val;
               bcd_sh <= '0;
               neg_r  <= exec_neg;
`ifdef EVAL_REMAINDER_EN
               rbin_sh <= {10'b0, rem_nx};
               rbcd_sh <= '0;
`endif
            end
         end
         if (state == S_CONV) begin
            bcd_sh <= {bcd_sh[22:20], bcd_adj, bin_sh[19]};
            bin_sh <= {bin_sh[18:0], 1'b0};
            cnt    <= cnt - 5'd1;
`ifdef EVAL_REMAINDER_EN
            rbcd_sh <= {rbcd_sh[10:8], rbcd_adj, rbin_sh[19]};
            rbin_sh <= {rbin_sh[18:0], 1'b0};
`endif
         end
         if (commit) begin
            if (op_r == OP_DIV) begin
`ifdef EVAL_REMAINDER_EN
               resultBCD <= {rbcd_sh, bcd_sh[11:0]};
`else
               resultBCD <= {12'h000, bcd_sh[11:0]};
`endif
            end else begin
               resultBCD <= bcd_sh;
            end
            negative <= neg_r;
            error    <= 1'b0;
            done     <= 1'b1;
         end
         if (fail) begin
            resultBCD <= '0;
            negative  <= 1'b0;
            error     <= 1'b1;
            done      <= 1'b1;
         end
      end
   end

endmodule
